// File: rtl/gates_checker.sv
// gates_checker: self-checking stage for the two-input logic-gate vector block.
// Each accepted sample is held for a settle window, then y[6:0] is compared
// against a truth table computed from the captured a/b. A run ends with a
// pass/fail verdict after NUM_VECTORS checks.
//
// Strobe semantics: start and sample are single-cycle strobes with no ready
// back-pressure. start is taken only in IDLE or DONE, where it wins over a
// coincident sample. sample is taken only in ARMED, and any sample seen in
// another state is dropped, never queued. The producer must hold a, b and y
// stable from the sample cycle through the CHECK cycle.
module gates_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int SETTLE      = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample,
    input  logic             a,
    input  logic             b,
    input  logic [7:0]       y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [6:0]       mismatch,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [1:0]       first_fail_ab,
    output logic             fail_seen,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
    localparam logic [CNT_W-1:0] NUM_V     = CNT_W'(NUM_VECTORS);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       settle_cnt;
    logic             cap_a;
    logic             cap_b;
    logic [6:0]       exp_y;
    logic [6:0]       diff;
    logic [CNT_W-1:0] vec_inc;
    logic             last_vec;
    logic             start_ok;
    logic             unused_y7;

    // y[7] carries no gate result and is deliberately not compared.
    assign unused_y7 = y[7];

    // Expected vector from the captured inputs, its difference to live y,
    // and run-control helpers.
    always_comb begin
        exp_y    = {~cap_a, ~(cap_a ^ cap_b), cap_a ^ cap_b, ~(cap_a & cap_b),
                    ~(cap_a | cap_b), cap_a & cap_b, cap_a | cap_b};
        diff     = exp_y ^ y[6:0];
        vec_inc  = vec_count + 1'b1;
        last_vec = (vec_inc == NUM_V);
        start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_ARMED;
            S_ARMED: begin
                if (sample) begin
                    if (SETTLE == 0) state_nxt = S_CHECK;
                    else             state_nxt = S_SETTLE;
                end
            end
            // The counter reaches zero on the edge that enters CHECK.
            S_SETTLE: if (settle_cnt <= 4'd1) state_nxt = S_CHECK;
            S_CHECK:  state_nxt = last_vec ? S_DONE : S_ARMED;
            S_DONE:   if (start) state_nxt = S_ARMED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy      = (state == S_ARMED) || (state == S_SETTLE) || (state == S_CHECK);
        done      = (state == S_DONE);
        pass      = done && (err_count == '0);
        state_dbg = state;
    end

    // Input capture and settle countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
            cap_a      <= 1'b0;
            cap_b      <= 1'b0;
        end else if (state == S_ARMED && sample) begin
            cap_a      <= a;
            cap_b      <= b;
            settle_cnt <= SETTLE_LD;
        end else if (state == S_SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Result bookkeeping: cleared by an accepted start, updated once per CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count      <= '0;
            err_count      <= '0;
            mismatch       <= 7'd0;
            first_fail_idx <= '0;
            first_fail_ab  <= 2'b00;
            fail_seen      <= 1'b0;
        end else if (start_ok) begin
            vec_count      <= '0;
            err_count      <= '0;
            mismatch       <= 7'd0;
            first_fail_idx <= '0;
            first_fail_ab  <= 2'b00;
            fail_seen      <= 1'b0;
        end else if (state == S_CHECK) begin
            mismatch  <= diff;
            vec_count <= vec_inc;
            if (diff != 7'd0) begin
                if (err_count != '1) err_count <= err_count + 1'b1;
                if (!fail_seen) begin
                    fail_seen      <= 1'b1;
                    first_fail_idx <= vec_count;
                    first_fail_ab  <= {cap_a, cap_b};
                end
            end
        end
    end

endmodule

// File: tb/tb_gates_checker.sv
// Bench for gates_checker: a default instance (4 vectors, settle 2, 8-bit
// counts) and a narrow instance (3 vectors, settle 0, 2-bit counts).
module tb_gates_checker;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam int M_SETTLE = 2;
    localparam int S_SETTLE = 0;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic       m_start, m_sample, m_a, m_b;
    logic [7:0] m_y;
    logic       m_busy, m_done, m_pass, m_fs;
    logic [7:0] m_vec, m_err, m_ffi;
    logic [6:0] m_mm;
    logic [1:0] m_ffab;
    logic [2:0] m_state;

    // narrow instance
    logic       s_start, s_sample, s_a, s_b;
    logic [7:0] s_y;
    logic       s_busy, s_done, s_pass, s_fs;
    logic [1:0] s_vec, s_err, s_ffi;
    logic [6:0] s_mm;
    logic [1:0] s_ffab;
    logic [2:0] s_state;

    gates_checker #(.NUM_VECTORS(4), .SETTLE(M_SETTLE), .CNT_W(8)) u_main (
        .clk(clk), .rst(rst), .start(m_start), .sample(m_sample),
        .a(m_a), .b(m_b), .y(m_y), .busy(m_busy), .done(m_done), .pass(m_pass),
        .vec_count(m_vec), .err_count(m_err), .mismatch(m_mm),
        .first_fail_idx(m_ffi), .first_fail_ab(m_ffab), .fail_seen(m_fs),
        .state_dbg(m_state)
    );

    gates_checker #(.NUM_VECTORS(3), .SETTLE(S_SETTLE), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .sample(s_sample),
        .a(s_a), .b(s_b), .y(s_y), .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_count(s_vec), .err_count(s_err), .mismatch(s_mm),
        .first_fail_idx(s_ffi), .first_fail_ab(s_ffab), .fail_seen(s_fs),
        .state_dbg(s_state)
    );

    // scoreboard
    int checks = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    // Reference truth table: [0]OR [1]AND [2]NOR [3]NAND [4]XOR [5]XNOR [6]NOT a
    function automatic logic [6:0] gate_model(input logic ia, input logic ib);
        logic [6:0] r;
        r[0] = ia | ib;
        r[1] = ia & ib;
        r[2] = ~(ia | ib);
        r[3] = ~(ia & ib);
        r[4] = ia ^ ib;
        r[5] = ~(ia ^ ib);
        r[6] = ~ia;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_vec(input bit sel);
        return sel ? {6'd0, s_vec} : m_vec;
    endfunction

    function automatic logic [2:0] get_state(input bit sel);
        return sel ? s_state : m_state;
    endfunction

    function automatic logic [6:0] get_mm(input bit sel);
        return sel ? s_mm : m_mm;
    endfunction

    // driver tasks
    task automatic drive_in(input bit sel, input logic ia, input logic ib,
                            input logic [7:0] iy, input logic smp);
        if (sel) begin
            s_a = ia; s_b = ib; s_y = iy; s_sample = smp;
        end else begin
            m_a = ia; m_b = ib; m_y = iy; m_sample = smp;
        end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) s_start = 1'b1;
        else     m_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        m_start = 1'b0;
    endtask

    // One vector: wait for ARMED, strobe sample, optionally strobe a stray
    // sample with inverted inputs during the settle window, then wait for the
    // count to move and score latency, count step and mismatch.
    task automatic send(input bit sel, input logic ia, input logic ib,
                        input logic [7:0] iy, input bit extra);
        logic [7:0] old;
        logic [6:0] e;
        int lat;
        bit armed;
        exp_q.push_back(gate_model(ia, ib) ^ iy[6:0]);
        armed = 1'b0;
        for (int i = 0; i < 20 && !armed; i++) begin
            @(negedge clk);
            if (get_state(sel) == ST_ARMED) armed = 1'b1;
        end
        chk("armed_wait", 32'(armed), 32'd1);
        drive_in(sel, ia, ib, iy, 1'b1);
        old = get_vec(sel);
        @(negedge clk);
        drive_in(sel, ia, ib, iy, 1'b0);
        lat = 0;
        if (extra) begin
            drive_in(sel, ~ia, ~ib, iy, 1'b1);
            @(posedge clk);
            #1;
            lat = 1;
            @(negedge clk);
            drive_in(sel, ia, ib, iy, 1'b0);
        end
        while (get_vec(sel) === old && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'((sel ? S_SETTLE : M_SETTLE) + 1));
        chk("vec_step", 32'(get_vec(sel)), 32'(old + 8'd1));
        e = exp_q.pop_front();
        chk("mismatch", 32'(get_mm(sel)), 32'(e));
    endtask

    task automatic run_clean;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            send(1'b0, ab[1], ab[0], {ab[0], gate_model(ab[1], ab[0])}, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_start = 0; m_sample = 0; m_a = 0; m_b = 0; m_y = 8'h00;
        s_start = 0; s_sample = 0; s_a = 0; s_b = 0; s_y = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_state", 32'(m_state), 32'(ST_IDLE));
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_pass", 32'(m_pass), 32'd0);
        chk("rst_vec", 32'(m_vec), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_mm", 32'(m_mm), 32'd0);
        chk("rst_ffi", 32'(m_ffi), 32'd0);
        chk("rst_ffab", 32'(m_ffab), 32'd0);
        chk("rst_fs", 32'(m_fs), 32'd0);
        chk("rst_s_state", 32'(s_state), 32'(ST_IDLE));
        chk("rst_s_busy", 32'(s_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // sample in IDLE is ignored
        drive_in(1'b0, 1'b1, 1'b1, 8'h00, 1'b1);
        @(negedge clk);
        drive_in(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle_sample", 32'(m_state), 32'(ST_IDLE));

        // run A: all vectors correct
        pulse_start(1'b0);
        chk("start_state", 32'(m_state), 32'(ST_ARMED));
        chk("start_busy", 32'(m_busy), 32'd1);
        run_clean();
        chk("a_state", 32'(m_state), 32'(ST_DONE));
        chk("a_done", 32'(m_done), 32'd1);
        chk("a_busy", 32'(m_busy), 32'd0);
        chk("a_pass", 32'(m_pass), 32'd1);
        chk("a_vec", 32'(m_vec), 32'd4);
        chk("a_err", 32'(m_err), 32'd0);
        chk("a_fs", 32'(m_fs), 32'd0);

        // run B: NOR stuck-1 on vector 10
        pulse_start(1'b0);
        chk("b_clr_vec", 32'(m_vec), 32'd0);
        chk("b_pass_busy", 32'(m_pass), 32'd0);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            logic [7:0] yv;
            ab = 2'(i);
            yv = {1'b0, gate_model(ab[1], ab[0])};
            if (i == 2) yv = yv | 8'h04;
            send(1'b0, ab[1], ab[0], yv, 1'b0);
            if (i == 2) chk("b_mm_fault", 32'(m_mm), 32'h04);
        end
        chk("b_done", 32'(m_done), 32'd1);
        chk("b_pass", 32'(m_pass), 32'd0);
        chk("b_err", 32'(m_err), 32'd1);
        chk("b_ffi", 32'(m_ffi), 32'd2);
        chk("b_ffab", 32'(m_ffab), 32'b10);
        chk("b_fs", 32'(m_fs), 32'd1);
        repeat (3) @(negedge clk);
        chk("b_hold_err", 32'(m_err), 32'd1);

        // run C: stray start while ARMED, stray sample during SETTLE
        pulse_start(1'b0);
        chk("c_clr_fs", 32'(m_fs), 32'd0);
        chk("c_clr_err", 32'(m_err), 32'd0);
        chk("c_clr_ffi", 32'(m_ffi), 32'd0);
        chk("c_clr_ffab", 32'(m_ffab), 32'd0);
        send(1'b0, 1'b1, 1'b1, {1'b0, gate_model(1'b1, 1'b1)}, 1'b0);
        pulse_start(1'b0);
        chk("c_start_ign_state", 32'(m_state), 32'(ST_ARMED));
        chk("c_start_ign_vec", 32'(m_vec), 32'd1);
        send(1'b0, 1'b1, 1'b1, {1'b0, gate_model(1'b1, 1'b1)}, 1'b1);
        send(1'b0, 1'b0, 1'b0, {1'b0, gate_model(1'b0, 1'b0)}, 1'b1);
        chk("c_vec_mid", 32'(m_vec), 32'd3);
        send(1'b0, 1'b0, 1'b1, {1'b0, gate_model(1'b0, 1'b1)}, 1'b0);
        chk("c_vec", 32'(m_vec), 32'd4);
        chk("c_pass", 32'(m_pass), 32'd1);

        // reset during SETTLE of vector 2, with a failure already recorded
        pulse_start(1'b0);
        send(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        @(negedge clk);
        drive_in(1'b0, 1'b1, 1'b0, {1'b0, gate_model(1'b1, 1'b0)}, 1'b1);
        @(negedge clk);
        drive_in(1'b0, 1'b1, 1'b0, {1'b0, gate_model(1'b1, 1'b0)}, 1'b0);
        chk("r_in_settle", 32'(m_state), 32'(ST_SETTLE));
        #2 rst = 1'b1;
        #1;
        chk("r_state", 32'(m_state), 32'(ST_IDLE));
        chk("r_busy", 32'(m_busy), 32'd0);
        chk("r_vec", 32'(m_vec), 32'd0);
        chk("r_err", 32'(m_err), 32'd0);
        chk("r_mm", 32'(m_mm), 32'd0);
        chk("r_fs", 32'(m_fs), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start(1'b0);
        chk("r2_vec", 32'(m_vec), 32'd0);
        run_clean();
        chk("r2_vec_end", 32'(m_vec), 32'd4);
        chk("r2_err", 32'(m_err), 32'd0);
        chk("r2_pass", 32'(m_pass), 32'd1);

        // narrow instance: every vector wrong, settle 0
        pulse_start(1'b1);
        send(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        send(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        send(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("s_done", 32'(s_done), 32'd1);
        chk("s_vec", 32'(s_vec), 32'd3);
        chk("s_err", 32'(s_err), 32'd3);
        chk("s_ffi", 32'(s_ffi), 32'd0);
        chk("s_ffab", 32'(s_ffab), 32'b00);
        chk("s_fs", 32'(s_fs), 32'd1);
        chk("s_pass", 32'(s_pass), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
